// File: rtl/overlay_banner_pkg.sv
// Shared types and default colours for the full-screen overlay banner.
// Imported by the interface, the hit sub-module and the top.
package overlay_pkg;

  typedef enum logic {IDLE, SHOW} ovl_state_t;
  typedef logic [23:0] rgb_t;

  localparam rgb_t DEF_BG_RGB  = 24'hFFFF80;
  localparam rgb_t DEF_COLOR_A = 24'hAE5700;
  localparam rgb_t DEF_COLOR_B = 24'hE0C41F;

endpackage

// File: rtl/overlay_banner_if.sv
// Pixel-pipeline bundle for the overlay: VGA counters and controls in,
// colour, busy and FSM state out.
interface overlay_banner_if #(
  parameter int H_W = 11,
  parameter int V_W = 10
);
  import overlay_pkg::*;

  // No valid/ready here: x_cnt/y_cnt are sampled on every clk edge.
  // trigger and clear are one-cycle strobes acted on at the edge they are high.
  // enable and mode are levels.
  logic [H_W-1:0] x_cnt;
  logic [V_W-1:0] y_cnt;
  logic           trigger;
  logic           clear;
  logic           enable;
  logic [1:0]     mode;
  rgb_t           overlay_RGB;
  logic           busy;
  ovl_state_t     dbg_state;

  modport master (
    output x_cnt, y_cnt, trigger, clear, enable, mode,
    input  overlay_RGB, busy, dbg_state
  );

  modport slave (
    input  x_cnt, y_cnt, trigger, clear, enable, mode,
    output overlay_RGB, busy, dbg_state
  );

endinterface

// File: rtl/overlay_banner_rect_hit.sv
// Registered inclusive rectangle membership test for one overlay layer.
// The result appears one clock after the coordinates are sampled.
module rect_hit #(
  parameter int H_W = 11,
  parameter int V_W = 10,
  parameter int X0  = 0,
  parameter int X1  = 0,
  parameter int Y0  = 0,
  parameter int Y1  = 0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [H_W-1:0] x,
  input  logic [V_W-1:0] y,
  output logic           hit
);

  always_ff @(posedge clk) begin
    if (reset) hit <= 1'b0;
    else       hit <= (x >= H_W'(X0)) && (x <= H_W'(X1)) &&
                      (y >= V_W'(Y0)) && (y <= V_W'(Y1));
  end

endmodule

// File: rtl/overlay_banner.sv
// Overlay renderer: nested alternating-colour rectangles shown for a hold
// time (or latched until clear), optionally blinking, with 2-cycle pixel latency.
module overlay_banner
  import overlay_pkg::*;
#(
  parameter int   H_W          = 11,
  parameter int   V_W          = 10,
  parameter int   NUM_LAYERS   = 3,
  parameter int   CX           = 400,
  parameter int   CY           = 250,
  parameter int   HW0          = 200,
  parameter int   HH0          = 100,
  parameter int   STEP         = 20,
  parameter int   HOLD_CYCLES  = 8000000,
  parameter int   BLINK_CYCLES = 4000000,
  parameter rgb_t BG_RGB       = DEF_BG_RGB,
  parameter rgb_t COLOR_A      = DEF_COLOR_A,
  parameter rgb_t COLOR_B      = DEF_COLOR_B
) (
  input  logic             clk,
  input  logic             reset,
  overlay_banner_if.slave  bus
);

  localparam int HC_W = (HOLD_CYCLES  > 1) ? $clog2(HOLD_CYCLES)  : 1;
  localparam int BC_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [HC_W-1:0] HOLD_LAST  = HC_W'(HOLD_CYCLES - 1);
  localparam logic [BC_W-1:0] BLINK_LAST = BC_W'(BLINK_CYCLES - 1);
  localparam int MIN_HALF = (HW0 < HH0) ? HW0 : HH0;

  if (CX < HW0)                           begin : g_bad_cx    $error("CX must be >= HW0"); end
  if (CY < HH0)                           begin : g_bad_cy    $error("CY must be >= HH0"); end
  if ((NUM_LAYERS - 1) * STEP >= MIN_HALF) begin : g_bad_step  $error("innermost layer collapses"); end
  if (NUM_LAYERS < 1 || NUM_LAYERS > 8)   begin : g_bad_layers $error("NUM_LAYERS out of 1..8"); end

  ovl_state_t      state_q, state_d;
  logic [HC_W-1:0] hold_q, hold_d;
  logic [BC_W-1:0] blink_q, blink_d;
  logic            phase_q, phase_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      blink_q <= '0;
      phase_q <= 1'b1;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      blink_q <= blink_d;
      phase_q <= phase_d;
    end
  end

  // clear beats trigger; trigger restarts even on the timeout cycle.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    blink_d = blink_q;
    phase_d = phase_q;
    if (bus.clear) begin
      state_d = IDLE;
    end else if (bus.trigger) begin
      state_d = SHOW;
      hold_d  = '0;
      blink_d = '0;
      phase_d = 1'b1;
    end else if (state_q == SHOW) begin
      if (hold_q == HOLD_LAST) begin
        if (!bus.mode[1]) state_d = IDLE;
      end else begin
        hold_d = hold_q + 1'b1;
      end
      if (bus.mode[0]) begin
        if (blink_q == BLINK_LAST) begin
          blink_d = '0;
          phase_d = ~phase_q;
        end else begin
          blink_d = blink_q + 1'b1;
        end
      end else begin
        blink_d = '0;
        phase_d = 1'b1;
      end
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.dbg_state = state_q;

  logic [NUM_LAYERS-1:0] hit;
  logic                  vis_q;
  rgb_t                  pix;

  for (genvar k = 0; k < NUM_LAYERS; k++) begin : g_layer
    rect_hit #(
      .H_W(H_W), .V_W(V_W),
      .X0(CX - HW0 + k * STEP), .X1(CX + HW0 - k * STEP),
      .Y0(CY - HH0 + k * STEP), .Y1(CY + HH0 - k * STEP)
    ) u_hit (
      .clk(clk), .reset(reset),
      .x(bus.x_cnt), .y(bus.y_cnt),
      .hit(hit[k])
    );
  end

  // Visibility rides alongside the hit flags so both stages stay aligned.
  always_ff @(posedge clk) begin
    if (reset) vis_q <= 1'b0;
    else       vis_q <= (state_q == SHOW) && phase_q && bus.enable;
  end

  // Innermost hit layer wins: later iterations override earlier ones.
  always_comb begin
    pix = BG_RGB;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      if (hit[k]) pix = (k % 2 == 0) ? COLOR_A : COLOR_B;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) bus.overlay_RGB <= BG_RGB;
    else       bus.overlay_RGB <= vis_q ? pix : BG_RGB;
  end

endmodule

// File: tb/tb_overlay_banner.sv
// Directed bench for overlay_banner with HOLD_CYCLES=10, BLINK_CYCLES=3 and
// default geometry; sample index k counts edges since the trigger edge.
module tb_overlay_banner;
  import overlay_pkg::*;

  localparam rgb_t BG = 24'hFFFF80;
  localparam rgb_t CA = 24'hAE5700;
  localparam rgb_t CB = 24'hE0C41F;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  overlay_banner_if #(.H_W(11), .V_W(10)) bus ();

  overlay_banner #(.HOLD_CYCLES(10), .BLINK_CYCLES(3)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_xy(input int x, input int y);
    bus.x_cnt = 11'(x);
    bus.y_cnt = 10'(y);
  endtask

  task automatic pulse_trigger();
    bus.trigger = 1'b1;
    step();
    bus.trigger = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 40 && bus.busy; i++) step();
    chk(tag, 32'(bus.busy), 32'(0));
    step(); step(); step();
  endtask

  int   gx[5]   = '{400, 230, 200, 199, 600};
  int   gy[5]   = '{250, 180, 150, 150, 350};
  rgb_t gexp[5] = '{CA, CB, CA, BG, CA};
  int   sx[4]   = '{400, 230, 600, 10};
  int   sy[4]   = '{250, 180, 350, 5};

  initial begin
    bus.trigger = 1'b0;
    bus.clear   = 1'b0;
    bus.enable  = 1'b1;
    bus.mode    = 2'b00;
    set_xy(400, 250);
    step(); step(); step();
    chk("reset_rgb", 32'(bus.overlay_RGB), 32'(BG));
    chk("reset_busy", 32'(bus.busy), 32'(0));
    chk("reset_state", 32'(bus.dbg_state), 32'(IDLE));
    reset = 1'b0;
    step();

    // First visible pixel: only the coordinates presented one cycle after trigger.
    set_xy(0, 0);
    pulse_trigger();
    set_xy(400, 250);
    step();
    chk("first_px_k2", 32'(bus.overlay_RGB), 32'(BG));
    set_xy(0, 0);
    step();
    chk("first_px_k3", 32'(bus.overlay_RGB), 32'(CA));
    step();
    chk("first_px_k4", 32'(bus.overlay_RGB), 32'(BG));
    wait_idle("first_px_idle");

    for (int i = 0; i < 5; i++) begin
      set_xy(gx[i], gy[i]);
      pulse_trigger();
      step(); step();
      chk($sformatf("geom_%0d_%0d", gx[i], gy[i]), 32'(bus.overlay_RGB), 32'(gexp[i]));
      wait_idle("geom_idle");
    end

    // Hold timing: busy for k=1..10, colour for k=3..12.
    set_xy(400, 250);
    pulse_trigger();
    for (int k = 1; k <= 14; k++) begin
      chk($sformatf("hold_busy_k%0d", k), 32'(bus.busy), 32'(k <= 10));
      chk($sformatf("hold_rgb_k%0d", k), 32'(bus.overlay_RGB), 32'((k >= 3 && k <= 12) ? CA : BG));
      step();
    end
    for (int i = 0; i < 4; i++) begin
      set_xy(sx[i], sy[i]);
      step(); step();
      chk($sformatf("idle_bg_%0d", i), 32'(bus.overlay_RGB), 32'(BG));
    end

    // Blink: phase visible for edges 1-3, hidden 4-6, ... rgb trails phase by 2.
    set_xy(400, 250);
    bus.mode = 2'b01;
    pulse_trigger();
    for (int k = 1; k <= 14; k++) begin
      chk($sformatf("blink_busy_k%0d", k), 32'(bus.busy), 32'(k <= 10));
      chk($sformatf("blink_rgb_k%0d", k), 32'(bus.overlay_RGB),
          32'((k >= 3 && k <= 12 && (((k - 3) / 3) % 2 == 0)) ? CA : BG));
      step();
    end
    bus.mode = 2'b00;
    wait_idle("blink_idle");

    // Retrigger on the timeout cycle (counter == 9).
    pulse_trigger();
    repeat (9) step();
    chk("retrig_busy_k10", 32'(bus.busy), 32'(1));
    pulse_trigger();
    begin
      int c;
      c = 0;
      while (bus.busy && c < 40) begin
        c++;
        step();
      end
      chk("retrig_len", 32'(c), 32'(10));
    end
    wait_idle("retrig_idle");

    // Latched mode.
    bus.mode = 2'b10;
    pulse_trigger();
    repeat (1000) step();
    chk("latch_busy", 32'(bus.busy), 32'(1));
    chk("latch_state", 32'(bus.dbg_state), 32'(SHOW));
    chk("latch_rgb", 32'(bus.overlay_RGB), 32'(CA));
    bus.clear = 1'b1;
    bus.trigger = 1'b1;
    step();
    bus.clear = 1'b0;
    bus.trigger = 1'b0;
    chk("clr_trig_busy", 32'(bus.busy), 32'(0));
    step(); step();
    chk("clr_trig_rgb", 32'(bus.overlay_RGB), 32'(BG));
    bus.mode = 2'b00;
    step();

    // Enable gate: timer keeps running, output stays background.
    pulse_trigger();
    bus.enable = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      chk($sformatf("gate_busy_k%0d", k), 32'(bus.busy), 32'(k <= 10));
      chk($sformatf("gate_rgb_k%0d", k), 32'(bus.overlay_RGB), 32'(BG));
      step();
    end
    bus.enable = 1'b1;

    // Clear alone in SHOW.
    pulse_trigger();
    step(); step();
    chk("clear_pre_rgb", 32'(bus.overlay_RGB), 32'(CA));
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    chk("clear_busy", 32'(bus.busy), 32'(0));
    step(); step();

    // Reset mid-SHOW.
    pulse_trigger();
    repeat (4) step();
    chk("rst_pre_busy", 32'(bus.busy), 32'(1));
    chk("rst_pre_rgb", 32'(bus.overlay_RGB), 32'(CA));
    reset = 1'b1;
    step();
    chk("rst_busy", 32'(bus.busy), 32'(0));
    chk("rst_rgb", 32'(bus.overlay_RGB), 32'(BG));
    chk("rst_state", 32'(bus.dbg_state), 32'(IDLE));
    reset = 1'b0;
    step();
    chk("rst_after_rgb", 32'(bus.overlay_RGB), 32'(BG));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
